// File: rtl/keypad_entry_buffer_if.sv
// Bundles keypad_scan's key/pressed inputs with the digit-buffer outputs of keypad_entry_buffer.
// slave is the buffer side; master is the side that drives keys and observes the digits.
interface keypad_entry_buffer_if;
  logic [3:0]  key;
  logic        pressed;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic [2:0]  count;
  logic        full;
  logic [15:0] value;
  logic        value_vld;

  modport master (
    output key,
    output pressed,
    input  digit0,
    input  digit1,
    input  digit2,
    input  digit3,
    input  count,
    input  full,
    input  value,
    input  value_vld
  );

  modport slave (
    input  key,
    input  pressed,
    output digit0,
    output digit1,
    output digit2,
    output digit3,
    output count,
    output full,
    output value,
    output value_vld
  );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Debounces keypad_scan's pressed flag into one accept per press and maintains a 4-digit right-entry buffer.
// Buffer updates DEB_CYCLES edges after the first pressed sample; there is no backpressure (value_vld is a pulse).
module keypad_entry_buffer #(
  parameter int         DEB_CYCLES = 4,
  parameter logic [3:0] KEY_BKSP   = 4'hB,
  parameter logic [3:0] KEY_CLR    = 4'hC,
  parameter logic [3:0] KEY_ENT    = 4'hE,
  parameter logic [3:0] BLANK      = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keypad_entry_buffer_if.slave kb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  localparam logic [3:0] DEB = 4'(DEB_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  r_cand;
  logic [3:0]  w_cand_nxt;
  logic        r_accept;
  logic        w_accept_nxt;
  logic        r_armed;

  logic [3:0]  r_digit0;
  logic [3:0]  r_digit1;
  logic [3:0]  r_digit2;
  logic [3:0]  r_digit3;
  logic [2:0]  r_count;
  logic [15:0] r_value;
  logic        r_value_vld;

  // r_armed stays low after reset until pressed is seen low, so a key still
  // held across reset release never produces an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_cand   <= 4'd0;
      r_accept <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cand   <= w_cand_nxt;
      r_accept <= w_accept_nxt;
      r_armed  <= r_armed | ~kb.pressed;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cand_nxt   = r_cand;
    w_accept_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (kb.pressed && r_armed) begin
          w_cand_nxt = kb.key;
          w_cnt_nxt  = 4'd1;
          if (DEB == 4'd1) begin
            w_state_nxt  = S_HELD;
            w_accept_nxt = 1'b1;
          end else begin
            w_state_nxt = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (!kb.pressed) begin
          w_state_nxt = S_IDLE;
        end else if (kb.key != r_cand) begin
          w_cand_nxt = kb.key;
          w_cnt_nxt  = 4'd1;
        end else if (r_cnt + 4'd1 == DEB) begin
          w_cnt_nxt    = DEB;
          w_state_nxt  = S_HELD;
          w_accept_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_HELD: begin
        // cand is frozen here: rollover to another key while held is ignored
        if (!kb.pressed) begin
          w_cnt_nxt   = 4'd1;
          w_state_nxt = (DEB == 4'd1) ? S_IDLE : S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (kb.pressed) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt + 4'd1 == DEB) begin
          w_cnt_nxt   = DEB;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit0    <= BLANK;
      r_digit1    <= BLANK;
      r_digit2    <= BLANK;
      r_digit3    <= BLANK;
      r_count     <= 3'd0;
      r_value     <= 16'hFFFF;
      r_value_vld <= 1'b0;
    end else begin
      r_value_vld <= 1'b0;
      if (r_accept) begin
        if (r_cand <= 4'd9) begin
          if (r_count != 3'd4) begin
            r_digit3 <= r_digit2;
            r_digit2 <= r_digit1;
            r_digit1 <= r_digit0;
            r_digit0 <= r_cand;
            r_count  <= r_count + 3'd1;
          end
        end else if (r_cand == KEY_BKSP) begin
          if (r_count != 3'd0) begin
            r_digit0 <= r_digit1;
            r_digit1 <= r_digit2;
            r_digit2 <= r_digit3;
            r_digit3 <= BLANK;
            r_count  <= r_count - 3'd1;
          end
        end else if (r_cand == KEY_CLR) begin
          r_digit0 <= BLANK;
          r_digit1 <= BLANK;
          r_digit2 <= BLANK;
          r_digit3 <= BLANK;
          r_count  <= 3'd0;
        end else if (r_cand == KEY_ENT) begin
          if (r_count != 3'd0) begin
            r_value     <= {r_digit3, r_digit2, r_digit1, r_digit0};
            r_value_vld <= 1'b1;
            r_digit0    <= BLANK;
            r_digit1    <= BLANK;
            r_digit2    <= BLANK;
            r_digit3    <= BLANK;
            r_count     <= 3'd0;
          end
        end
      end
    end
  end

  assign kb.digit0    = r_digit0;
  assign kb.digit1    = r_digit1;
  assign kb.digit2    = r_digit2;
  assign kb.digit3    = r_digit3;
  assign kb.count     = r_count;
  assign kb.full      = (r_count == 3'd4);
  assign kb.value     = r_value;
  assign kb.value_vld = r_value_vld;

endmodule
